// File: rtl/temp_qsys_ram_pkg.sv
// temp_qsys_ram_pkg: shared FSM state type and read-latency constant for the
// burst on-chip RAM. Build option TEMP_QSYS_RAM_OUTREG_EN adds a RAM output
// register and raises the read latency from 1 to 2.
package temp_qsys_ram_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } state_e;

`ifdef TEMP_QSYS_RAM_OUTREG_EN
  localparam int RD_LATENCY = 2;
`else
  localparam int RD_LATENCY = 1;
`endif

endpackage

// File: rtl/temp_qsys_ram_core.sv
// temp_qsys_ram_core: byte-enabled single-port RAM with clock enable and a
// registered read port. Build option TEMP_QSYS_RAM_OUTREG_EN adds a second
// output register stage. INIT_FILE other than "UNUSED" tags the array with a
// vendor init-file attribute; otherwise contents start undefined.
module temp_qsys_ram_core #(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 15,
  parameter string INIT_FILE = "UNUSED"
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_ce,
  input  logic                i_we,
  input  logic                i_re,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] w_mem_rd;
  logic [DATA_W-1:0] r_q;

  if (INIT_FILE != "UNUSED") begin : g_init
    (* ram_init_file = INIT_FILE *) logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the storage array has no reset; only the small output registers do.
    // Byte-masked write port.
    always_ff @(posedge clk) begin
      if (i_ce && i_we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end

    assign w_mem_rd = r_mem[i_addr];
  end else begin : g_noinit
    logic [DATA_W-1:0] r_mem [DEPTH];

    // Byte-masked write port.
    always_ff @(posedge clk) begin
      if (i_ce && i_we) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          if (i_be[b]) r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end

    assign w_mem_rd = r_mem[i_addr];
  end

  // Registered read: captures the word only on an issued read so the last
  // returned beat stays on the bus afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_ce && i_re) begin
      r_q <= w_mem_rd;
    end
  end

`ifdef TEMP_QSYS_RAM_OUTREG_EN
  logic [DATA_W-1:0] r_q2;

  // Optional output stage; advances with the clock enable like the valid pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q2 <= '0;
    end else if (i_ce) begin
      r_q2 <= r_q;
    end
  end

  assign o_rdata = r_q2;
`else
  assign o_rdata = r_q;
`endif

endmodule

// File: rtl/temp_qsys_onchip_ram_burst.sv
// temp_qsys_onchip_ram_burst: Avalon-MM burst slave in front of a single-port
// on-chip RAM. Writes are accepted beat by beat; reads are issued one address
// per cycle and returned in order after RD_LATENCY cycles. clken low or
// reset_req high freezes everything. Build option TEMP_QSYS_RAM_OUTREG_EN
// selects read latency 2 instead of 1.
module temp_qsys_onchip_ram_burst
  import temp_qsys_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    ADDR_W    = 15,
  parameter int    BURST_W   = 4,
  parameter string INIT_FILE = "UNUSED"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  input  logic                clken,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [BURST_W-1:0]  burstcount,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest
);

  state_e              r_state, w_state_nxt;
  logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
  logic [BURST_W-1:0]  r_beat_cnt, w_beat_nxt;   // beats still to write / issue
  logic [BURST_W-1:0]  r_ret_cnt, w_ret_nxt;     // read beats still to return
  logic                r_wait, w_wait_nxt;
  logic [RD_LATENCY-1:0] r_vld;

  logic                w_ce;
  logic [BURST_W-1:0]  w_cmd_len;
  logic                w_mem_we;
  logic                w_mem_re;
  logic [ADDR_W-1:0]   w_mem_addr;

  assign w_ce      = clken & ~reset_req;
  assign w_cmd_len = (burstcount == '0) ? BURST_W'(1) : burstcount;

  // A beat leaves the pipe only in an enabled cycle, so a stalled beat is
  // shown exactly once when the clock enable returns.
  assign readdatavalid = r_vld[RD_LATENCY-1] & w_ce;
  assign waitrequest   = r_wait;
  assign w_wait_nxt    = (w_state_nxt == RD_BURST) || (w_state_nxt == RD_DRAIN);

  // Next-state, RAM port control and counter updates.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_beat_nxt  = r_beat_cnt;
    w_ret_nxt   = r_ret_cnt;
    w_mem_we    = 1'b0;
    w_mem_re    = 1'b0;
    w_mem_addr  = r_addr;
    if (w_ce) begin
      unique case (r_state)
        IDLE: begin
          w_mem_addr = address;
          if (chipselect && !r_wait) begin
            if (write) begin
              // Write wins over a simultaneous read; beat 1 goes straight in.
              w_mem_we   = 1'b1;
              w_addr_nxt = address + 1'b1;
              w_beat_nxt = w_cmd_len - 1'b1;
              if (w_cmd_len != BURST_W'(1)) w_state_nxt = WR_BURST;
            end else if (read) begin
              w_addr_nxt  = address;
              w_beat_nxt  = w_cmd_len;
              w_ret_nxt   = w_cmd_len;
              w_state_nxt = RD_BURST;
            end
          end
        end
        WR_BURST: begin
          if (write) begin
            w_mem_we   = 1'b1;
            w_addr_nxt = r_addr + 1'b1;
            w_beat_nxt = r_beat_cnt - 1'b1;
            if (r_beat_cnt == BURST_W'(1)) w_state_nxt = IDLE;
          end
        end
        RD_BURST: begin
          w_mem_re   = 1'b1;
          w_addr_nxt = r_addr + 1'b1;
          w_beat_nxt = r_beat_cnt - 1'b1;
          if (r_beat_cnt == BURST_W'(1)) w_state_nxt = RD_DRAIN;
        end
        RD_DRAIN: begin
          if (readdatavalid && r_ret_cnt == BURST_W'(1)) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
      if (readdatavalid) w_ret_nxt = r_ret_cnt - 1'b1;
    end
  end

  // FSM, address and counter registers; waitrequest is high through reset and
  // drops on the first edge after release.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_beat_cnt <= '0;
      r_ret_cnt  <= '0;
      r_wait     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_beat_cnt <= w_beat_nxt;
      r_ret_cnt  <= w_ret_nxt;
      r_wait     <= w_wait_nxt;
    end
  end

  // Read-valid pipe matching the RAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
    end else if (w_ce) begin
      r_vld[0] <= w_mem_re;
      for (int i = 1; i < RD_LATENCY; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  temp_qsys_ram_core #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk     (clk),
    .rst     (reset),
    .i_ce    (w_ce),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_mem_addr),
    .i_be    (byteenable),
    .i_wdata (writedata),
    .o_rdata (readdata)
  );

endmodule

// File: tb/tb_temp_qsys_onchip_ram_burst.sv
// Testbench for temp_qsys_onchip_ram_burst: directed Avalon bursts plus random
// traffic, checked by a scoreboard against a word-level memory model.
module tb_temp_qsys_onchip_ram_burst;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 15;
  localparam int BURST_W = 4;
`ifdef TEMP_QSYS_RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                clk;
  logic                reset;
  logic                reset_req;
  logic                clken;
  logic                chipselect;
  logic                read;
  logic                write;
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic                waitrequest;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    bit                known;
  } exp_t;

  exp_t              exp_q[$];
  logic [DATA_W-1:0] model [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] wd  [8];
  logic [3:0]        wbe [8];
  int                n_cmp  = 0;
  int                n_fail = 0;

  temp_qsys_onchip_ram_burst #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .BURST_W (BURST_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .reset_req     (reset_req),
    .clken         (clken),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .address       (address),
    .burstcount    (burstcount),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference memory: byte lanes merged into the stored word.
  function automatic void model_write(input logic [ADDR_W-1:0] a,
                                      input logic [DATA_W-1:0] d, input logic [3:0] be);
    logic [DATA_W-1:0] w;
    w = model.exists(a) ? model[a] : '0;
    for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = d[b*8 +: 8];
    model[a] = w;
  endfunction

  // Monitor: every presented beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (readdatavalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "rd_unexpected_beat", readdata, '0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.known) check(readdata === e.d, $sformatf("rd_data@%04h", e.a), readdata, e.d);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (waitrequest !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(n < 100, "cmd_ready_timeout", DATA_W'(n), 32'd100);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input int len,
                          input bit stalls, input bit with_read);
    int n = (len == 0) ? 1 : len;
    logic [ADDR_W-1:0] wa = a;
    wait_ready();
    chipselect = 1'b1; write = 1'b1; read = with_read;
    address = a; burstcount = BURST_W'(len); writedata = wd[0]; byteenable = wbe[0];
    @(posedge clk); #1;
    model_write(wa, wd[0], wbe[0]);
    chipselect = 1'b0; read = 1'b0;
    for (int i = 1; i < n; i++) begin
      address = ADDR_W'($urandom);
      while (stalls && $urandom_range(0, 2) == 0) begin
        write = 1'b0; writedata = $urandom; byteenable = 4'hF;
        @(posedge clk); #1;
      end
      wa = wa + 1'b1;
      write = 1'b1; writedata = wd[i]; byteenable = wbe[i];
      @(posedge clk); #1;
      model_write(wa, wd[i], wbe[i]);
    end
    write = 1'b0;
  endtask

  // stall_sel: 0 drops clken, 1 raises reset_req, for stall_cycles after beat stall_after.
  task automatic do_read(input logic [ADDR_W-1:0] a, input int len,
                         input int stall_after, input int stall_cycles, input bit stall_sel);
    int n = (len == 0) ? 1 : len;
    int beats = 0;
    int cyc = 0;
    wait_ready();
    chipselect = 1'b1; read = 1'b1; address = a; burstcount = BURST_W'(len);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.a = a + ADDR_W'(i);
      e.known = model.exists(e.a);
      e.d = e.known ? model[e.a] : '0;
      exp_q.push_back(e);
    end
    while (beats < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check(waitrequest === 1'b1, "rd_wait_hold", {31'b0, waitrequest}, 32'd1);
      if (readdatavalid === 1'b1) begin
        if (beats == 0) check(cyc == LAT + 1, "rd_latency", DATA_W'(cyc - 1), DATA_W'(LAT));
        beats++;
        if (beats == stall_after && stall_cycles > 0) begin
          @(posedge clk); #1;
          if (stall_sel) reset_req = 1'b1; else clken = 1'b0;
          for (int s = 0; s < stall_cycles; s++) begin
            @(negedge clk);
            cyc++;
            check(readdatavalid === 1'b0, "stall_no_beat", {31'b0, readdatavalid}, 32'd0);
            check(waitrequest === 1'b1, "stall_wait", {31'b0, waitrequest}, 32'd1);
          end
          @(posedge clk); #1;
          reset_req = 1'b0; clken = 1'b1;
        end
      end
    end
    check(beats == n, "rd_beat_count", DATA_W'(beats), DATA_W'(n));
    @(negedge clk);
    check(waitrequest === 1'b0, "rd_wait_release", {31'b0, waitrequest}, 32'd0);
  endtask

  task automatic do_read_reset(input logic [ADDR_W-1:0] a);
    int beats = 0;
    int cyc = 0;
    wait_ready();
    chipselect = 1'b1; read = 1'b1; address = a; burstcount = BURST_W'(8);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.a = a + ADDR_W'(i);
      e.known = model.exists(e.a);
      e.d = e.known ? model[e.a] : '0;
      exp_q.push_back(e);
    end
    while (beats < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (readdatavalid === 1'b1) beats++;
    end
    check(beats == 3, "rst_reach_beat3", DATA_W'(beats), 32'd3);
    #1 reset = 1'b1;
    #1;
    check(readdatavalid === 1'b0, "rst_rdv_async", {31'b0, readdatavalid}, 32'd0);
    check(waitrequest === 1'b1, "rst_wait_async", {31'b0, waitrequest}, 32'd1);
    check(readdata === '0, "rst_rdata_async", readdata, '0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check(waitrequest === 1'b1, "rst_wait_before_edge", {31'b0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    check(waitrequest === 1'b0, "rst_wait_after_edge", {31'b0, waitrequest}, 32'd0);
    repeat (10) begin
      @(negedge clk);
      check(readdatavalid === 1'b0, "rst_no_more_beats", {31'b0, readdatavalid}, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; reset_req = 1'b0; clken = 1'b1; chipselect = 1'b0;
    read = 1'b0; write = 1'b0; address = '0; burstcount = '0;
    byteenable = '0; writedata = '0;
    #2 reset = 1'b1;

    // Reset state and release timing.
    @(negedge clk);
    check(waitrequest === 1'b1, "reset_wait", {31'b0, waitrequest}, 32'd1);
    check(readdatavalid === 1'b0, "reset_rdv", {31'b0, readdatavalid}, 32'd0);
    check(readdata === '0, "reset_rdata", readdata, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check(waitrequest === 1'b1, "release_wait_hold", {31'b0, waitrequest}, 32'd1);
    @(posedge clk); #1;
    check(waitrequest === 1'b0, "release_wait_drop", {31'b0, waitrequest}, 32'd0);

    // Prefill the two test regions (low words and the wrap-around top words).
    for (int r = 0; r < 9; r++) begin
      for (int i = 0; i < 8; i++) begin wd[i] = $urandom; wbe[i] = 4'hF; end
      do_write((r == 8) ? 15'h7FF8 : ADDR_W'(r * 8), 8, 1'b0, 1'b0);
    end

    // Single write / single read.
    wd[0] = 32'hDEADBEEF; wbe[0] = 4'hF;
    do_write(15'h0010, 1, 1'b0, 1'b0);
    do_read(15'h0010, 1, 0, 0, 1'b0);

    // Wrapping write burst with stalls, then wrapping read burst.
    for (int i = 0; i < 4; i++) begin wd[i] = DATA_W'(i + 1); wbe[i] = 4'hF; end
    do_write(15'h7FFE, 4, 1'b1, 1'b0);
    do_read(15'h7FFE, 4, 0, 0, 1'b0);

    // Byte-enable merge.
    wd[0] = 32'hFFFFFFFF; wbe[0] = 4'hF;
    do_write(15'h0020, 1, 1'b0, 1'b0);
    wd[0] = 32'h11223344; wbe[0] = 4'h5;
    do_write(15'h0020, 1, 1'b0, 1'b0);
    check(model[15'h0020] === 32'hFF22FF44, "model_be_merge", model[15'h0020], 32'hFF22FF44);
    do_read(15'h0020, 1, 0, 0, 1'b0);

    // Read and write together: only the write happens.
    wd[0] = 32'hA5A55A5A; wbe[0] = 4'hF;
    do_write(15'h0021, 1, 1'b0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check(readdatavalid === 1'b0, "rw_no_read_beat", {31'b0, readdatavalid}, 32'd0);
    end
    do_read(15'h0021, 1, 0, 0, 1'b0);

    // Mid-burst freezes via clken and via reset_req.
    do_read(15'h0000, 8, 3, 3, 1'b0);
    do_read(15'h7FFC, 8, 5, 2, 1'b1);

    // Random traffic inside the prefilled regions.
    for (int t = 0; t < 40; t++) begin
      logic [ADDR_W-1:0] a;
      int len;
      a = ($urandom_range(0, 1) == 1) ? ADDR_W'(15'h7FF8 + $urandom_range(0, 7))
                                      : ADDR_W'($urandom_range(0, 'h37));
      len = $urandom_range(0, 8);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; wbe[i] = 4'($urandom); end
        do_write(a, len, 1'b1, 1'b0);
      end else begin
        do_read(a, len, 0, 0, 1'b0);
      end
    end

    // Reset in the middle of a read burst; memory contents survive.
    do_read_reset(15'h0008);
    do_read(15'h0010, 8, 0, 0, 1'b0);

    repeat (10) @(negedge clk);
    check(exp_q.size() == 0, "scoreboard_drained", DATA_W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/temp_qsys_onchip_ram_burst.md
TEMP_QSYS_ONCHIP_RAM_BURST -- requirements
Module: temp_qsys_onchip_ram_burst

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data bus width; a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 15, word address width; depth = 2**ADDR_W words.
REQ-003 SHALL have parameter BURST_W, default 4, burstcount width; maximum burst = 2**(BURST_W-1) beats.
REQ-004 SHALL have parameter INIT_FILE, default "UNUSED", memory init file; "UNUSED" means contents are undefined.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port reset_req, input, 1, memory-protect request; same effect as clken low.
REQ-008 SHALL have port clken, input, 1, global clock enable.
REQ-009 SHALL have port chipselect, input, 1; a command is present only when chipselect=1.
REQ-010 SHALL have ports read and write, input, 1 each; Avalon-MM command strobes.
REQ-011 SHALL have port address, input, ADDR_W, word address of the first beat.
REQ-012 SHALL have port burstcount, input, BURST_W, beats in the burst.
REQ-013 SHALL have ports byteenable, input, DATA_W/8, and writedata, input, DATA_W.
REQ-014 SHALL have ports readdata, output, DATA_W; readdatavalid, output, 1; waitrequest, output, 1.

Function
REQ-015 SHALL implement FSM states IDLE, WR_BURST, RD_BURST and RD_DRAIN.
REQ-016 SHALL treat burstcount=0 as 1.
REQ-017 SHALL accept a command in IDLE when chipselect=1, waitrequest=0 and clken=1.
REQ-018 SHALL give write priority if read and write are both high; the read is dropped.
REQ-019 Write beat 1: SHALL write writedata to address with byteenable masking; if the burst is >1 beat, go to WR_BURST.
REQ-020 WR_BURST: SHALL take one beat per cycle with write=1 at an internal address +1; address input ignored; cycles with write=0 stall; return to IDLE after the last beat.
REQ-021 Read accept: SHALL latch address and count, go to RD_BURST and issue one RAM read per cycle; waitrequest=1 from the accept edge until the last readdatavalid.
REQ-022 RD_BURST: after the last issue, SHALL go to RD_DRAIN until all in-flight beats are returned, then go to IDLE.
REQ-023 SHALL assert readdatavalid for exactly one cycle per beat, in address order, L cycles after the RAM address is issued; L=1 (see REQ-030).
REQ-024 SHALL wrap internal burst addresses from 2**ADDR_W-1 to 0.
REQ-025 SHALL freeze FSM, counters, pipeline and RAM port while clken=0 or reset_req=1; no writes, no new readdatavalid; resume without loss.
REQ-026 Read-during-write is impossible by construction (one port, serialised FSM); no bypass is required.

Reset
REQ-027 On reset assertion, SHALL asynchronously set FSM=IDLE, counters=0, readdatavalid=0, readdata=0, waitrequest=1.
REQ-028 SHALL drive waitrequest=0 on the first clk edge after reset deasserts; memory contents are not reset.
REQ-029 Reset mid-burst SHALL abort the burst: no further writes occur and no further readdatavalid pulses occur.

Configuration
REQ-030 Macro TEMP_QSYS_RAM_OUTREG_EN: when defined, SHALL add an output register after the RAM (L=2), with readdatavalid delayed to match; when undefined, L=1.

Structure
REQ-031 Package temp_qsys_ram_pkg SHALL hold the FSM state enum and the latency constant derived from the macro.
REQ-032 Sub-module temp_qsys_ram_core SHALL be the byte-enabled single-port RAM (INIT_FILE, clock enable, optional output register).

Verification
REQ-033 Single write 0x0010 = 0xDEADBEEF with byteenable 0xF, then read 0x0010 with burstcount 1 -> one readdatavalid, L cycles after issue, data 0xDEADBEEF.
REQ-034 Write burst of 4 at 0x7FFE with data 1,2,3,4, then read burst of 4 at 0x7FFE -> readdatavalid x4 returning 1,2,3,4; addresses wrap to 0x0000 and 0x0001.
REQ-035 Write 0x11223344 with byteenable 0x5 over 0xFFFFFFFF -> read returns 0xFF22FF44.
REQ-036 Read burst of 8 with clken=0 for 3 cycles mid-burst -> 8 ordered beats; waitrequest stays 1 until the last beat; no beats during the stall.
REQ-037 Reset pulse during beat 3 of a read burst of 8 -> readdatavalid=0 immediately; waitrequest=1, then 0 one edge after release.
REQ-038 read=write=1 with burstcount 1 -> write performed; no readdatavalid.
